seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Parametrised multiplexed seven-segment scan driver: time-multiplexes NUM_DIGITS segment patterns onto one shared segment bus and a one-hot digit select. Has an internal dwell counter, a blanking gap between digits for anti-ghosting, per-digit masking, configurable output polarity and a frame-done pulse. Sits between the display-formatting logic and the board pins, and replaces the fixed four-digit driver.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (≥2)
- SEG_W, 7, segment lines per digit (7, or 8 with decimal point)
- DWELL, 1000, clock cycles each digit is driven (≥1)
- GAP, 16, blanking cycles before each digit (≥0; 0 = no gap)
- SEG_ACT_LOW, 1, 1 = segment outputs active-low
- SEL_ACT_LOW, 0, 1 = select outputs active-low
- clk_disp  in  1  display clock; sole clock, all flops on rising edge
- rst  in  1  asynchronous, active-high reset
- disp_enable  in  1  1 = scan running, 0 = display dark
- seg_data  in  NUM_DIGITS*SEG_W  flat patterns, active-high segment-on; digit i = bits [i*SEG_W +: SEG_W]
- digit_mask  in  NUM_DIGITS  1 = digit i shown, 0 = slot kept but dark
- catodo  out  SEG_W  segment drive, polarity per SEG_ACT_LOW
- seleccion  out  NUM_DIGITS  one-hot digit select, polarity per SEL_ACT_LOW
- frame_done  out  1  one-cycle pulse at end of last digit's dwell

## Operation
- "Off" means catodo all segments inactive, seleccion all inactive, after polarity.
- Reset (async): state IDLE, idx=0, counters 0, outputs off, frame_done=0.
- FSM states IDLE, BLANK, SHOW; idx counts 0..NUM_DIGITS-1. catodo, seleccion and frame_done are registers.
- IDLE: outputs off. If disp_enable=1, go to BLANK with idx=0 and cnt=0 (to SHOW directly if GAP=0).
- BLANK: outputs off. cnt counts 0..GAP-1, then go to SHOW with cnt=0.
- SHOW entry: latch slice idx of seg_data and bit idx of digit_mask. The latched value is held for the whole dwell, so there is no tearing.
- SHOW: catodo = latched pattern, polarity applied. seleccion bit idx active if the latched mask bit is 1, otherwise off. cnt counts 0..DWELL-1.
- SHOW end (cnt=DWELL-1):
  - If idx=NUM_DIGITS-1, set idx=0 and pulse frame_done in the same cycle.
  - Otherwise set idx=idx+1.
  - Go to BLANK (or SHOW if GAP=0).
- disp_enable=0 in any state: at the next edge go to IDLE, outputs off, idx=0, cnt=0. No frame_done. Takes priority over the dwell-end transition.
- Never more than one seleccion bit active at once.
- Counter width is $clog2(max(DWELL,GAP,2)). idx width is $clog2(NUM_DIGITS).

## Timing
- disp_enable sampled high at edge E0: outputs stay off for GAP cycles after E0, then digit 0 is driven for DWELL cycles.
- Frame period is NUM_DIGITS*(GAP+DWELL) cycles.
- frame_done is high during the final SHOW cycle of digit NUM_DIGITS-1.
- seg_data and digit_mask changes take effect at the next SHOW entry.
- disp_enable falling edge: outputs off one edge later.
- rst asserted mid-scan: outputs off immediately (asynchronous). The scan restarts from IDLE after release.

## Configuration
- Macro SEG_SCAN_PWM_EN.
- Defined: adds input brightness (4 bits), latched at each SHOW entry.
  - A 4-bit phase counter clears at SHOW entry and increments every SHOW cycle.
  - The selected digit is active only while phase < brightness. brightness=15 forces full duty; brightness=0 keeps the digit dark.
  - catodo is unaffected.
- Undefined: no brightness port; full duty, as in Operation.

## Test plan
- Parameters NUM_DIGITS=4, DWELL=4, GAP=1, SEG_ACT_LOW=1, SEL_ACT_LOW=0 unless noted.
- Reset: assert rst mid-SHOW -> catodo=7'h7F, seleccion=4'b0000 without a clock edge; release, disp_enable=1 -> 1 blank cycle, then seleccion=4'b0001 for 4 cycles.
- Full scan: seg_data={7'h4F,7'h5B,7'h06,7'h3F} -> catodo=~7'h3F with sel 0001, ~7'h06 with 0010, ~7'h5B with 0100, ~7'h4F with 1000; 1 blank cycle between digits; frame_done high only in the 20th cycle; frame repeats every 20 cycles.
- Mask: digit_mask=4'b1011 -> digit 2 slot keeps 5-cycle timing with seleccion=0000; the others are driven normally.
- Disable mid-dwell: drop disp_enable during digit 2 -> off next edge, no frame_done; re-enable -> restarts at digit 0 after the gap.
- Tearing and GAP=0: change seg_data during a dwell -> output changes only at the next digit; with GAP=0, digits are back to back and the frame is 16 cycles.
- With SEG_SCAN_PWM_EN and DWELL=16: brightness=4 -> seleccion active 4 of 16 cycles; brightness=15 -> 16/16; brightness=0 -> 0/16.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with per-digit blanking gap, masking and output polarity.
// Optional macro SEG_SCAN_PWM_EN adds a 4-bit brightness input that gates the digit select.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int SEG_W       = 7,
    parameter int DWELL       = 1000,
    parameter int GAP         = 16,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b0
) (
    input  logic                        clk_disp,
    input  logic                        rst,
    input  logic                        disp_enable,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_data,
    input  logic [NUM_DIGITS-1:0]       digit_mask,
`ifdef SEG_SCAN_PWM_EN
    input  logic [3:0]                  brightness,
`endif
    output logic [SEG_W-1:0]            catodo,
    output logic [NUM_DIGITS-1:0]       seleccion,
    output logic                        frame_done
);

    localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0]         DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0]         GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [SEG_W-1:0]      SEG_OFF    = {SEG_W{SEG_ACT_LOW}};
    localparam logic [NUM_DIGITS-1:0] SEL_OFF    = {NUM_DIGITS{SEL_ACT_LOW}};

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SEG_W-1:0]        pat_q, pat_d;
    logic                    mask_q, mask_d;
    logic [SEG_W-1:0]        catodo_q, catodo_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    fd_q, fd_d;
    logic                    enter_show;
    logic                    duty_on;
    logic [NUM_DIGITS-1:0]   sel_hot;
`ifdef SEG_SCAN_PWM_EN
    logic [3:0]              bright_q, bright_d;
    logic [3:0]              phase_q, phase_d;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        pat_d      = pat_q;
        mask_d     = mask_q;
        enter_show = 1'b0;

        // Dropping the enable wins over any dwell-end transition.
        if (!disp_enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    idx_d = '0;
                    cnt_d = '0;
                    if (GAP == 0) begin
                        state_d    = SHOW;
                        enter_show = 1'b1;
                    end else begin
                        state_d = BLANK;
                    end
                end
                BLANK: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d    = SHOW;
                        cnt_d      = '0;
                        enter_show = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        if (GAP == 0) begin
                            state_d    = SHOW;
                            enter_show = 1'b1;
                        end else begin
                            state_d = BLANK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Pattern and mask are frozen for the whole dwell so a mid-dwell update cannot tear.
        if (enter_show) begin
            pat_d  = seg_data[idx_d*SEG_W +: SEG_W];
            mask_d = digit_mask[idx_d];
        end

`ifdef SEG_SCAN_PWM_EN
        bright_d = bright_q;
        phase_d  = phase_q + 4'd1;
        if (enter_show) begin
            bright_d = brightness;
            phase_d  = 4'd0;
        end
        duty_on = (bright_d == 4'hF) || (phase_d < bright_d);
`else
        duty_on = 1'b1;
`endif

        sel_hot        = '0;
        sel_hot[idx_d] = 1'b1;

        // Outputs are registered, so they are derived from the state being entered.
        catodo_d = SEG_OFF;
        sel_d    = SEL_OFF;
        if (state_d == SHOW) begin
            catodo_d = pat_d ^ SEG_OFF;
            if (mask_d && duty_on) begin
                sel_d = sel_hot ^ SEL_OFF;
            end
        end
        fd_d = (state_d == SHOW) && (idx_d == IDX_LAST) && (cnt_d == DWELL_LAST);
    end

    always_ff @(posedge clk_disp or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            pat_q    <= '0;
            mask_q   <= 1'b0;
            catodo_q <= SEG_OFF;
            sel_q    <= SEL_OFF;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            mask_q   <= mask_d;
            catodo_q <= catodo_d;
            sel_q    <= sel_d;
            fd_q     <= fd_d;
        end
    end

`ifdef SEG_SCAN_PWM_EN
    always_ff @(posedge clk_disp or posedge rst) begin
        if (rst) begin
            bright_q <= 4'd0;
            phase_q  <= 4'd0;
        end else begin
            bright_q <= bright_d;
            phase_q  <= phase_d;
        end
    end
`endif

    assign catodo     = catodo_q;
    assign seleccion  = sel_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: table-driven frame scans against a timing scoreboard,
// plus hand sequences for reset, disable, tearing, GAP=0 and (with SEG_SCAN_PWM_EN) brightness.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst, en, en0;
    logic [27:0] seg;
    logic [3:0]  mask;
    logic [6:0]  cat, cat0;
    logic [3:0]  sel, sel0;
    logic        fd, fd0;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(4), .SEG_W(7), .DWELL(4), .GAP(1),
                      .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b0)) dut (
        .clk_disp(clk), .rst(rst), .disp_enable(en), .seg_data(seg), .digit_mask(mask),
`ifdef SEG_SCAN_PWM_EN
        .brightness(4'hF),
`endif
        .catodo(cat), .seleccion(sel), .frame_done(fd));

    seg_scan_driver #(.NUM_DIGITS(4), .SEG_W(7), .DWELL(4), .GAP(0),
                      .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b0)) dut0 (
        .clk_disp(clk), .rst(rst), .disp_enable(en0), .seg_data(seg), .digit_mask(mask),
`ifdef SEG_SCAN_PWM_EN
        .brightness(4'hF),
`endif
        .catodo(cat0), .seleccion(sel0), .frame_done(fd0));

`ifdef SEG_SCAN_PWM_EN
    logic       enp;
    logic [3:0] bri;
    logic [6:0] catp;
    logic [3:0] selp;
    logic       fdp;
    seg_scan_driver #(.NUM_DIGITS(4), .SEG_W(7), .DWELL(16), .GAP(1),
                      .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b0)) dutp (
        .clk_disp(clk), .rst(rst), .disp_enable(enp), .seg_data(seg), .digit_mask(mask),
        .brightness(bri), .catodo(catp), .seleccion(selp), .frame_done(fdp));
`endif

    typedef struct packed {
        logic [6:0] cat;
        logic [3:0] sel;
        logic       fd;
    } out_t;

    typedef struct {
        logic [27:0] seg;
        logic [3:0]  mask;
        int          sel_cycles;
    } vec_t;

    localparam out_t OFF = '{cat: 7'h7F, sel: 4'b0000, fd: 1'b0};

    out_t expq[$];
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[4];

    // Expected pins t cycles after the enabling edge, straight from the frame timing.
    function automatic out_t expect_at(int t, logic [27:0] s, logic [3:0] m, int gap);
        int   slot = gap + 4;
        int   pos  = (t - 1) % (4 * slot);
        int   d    = pos / slot;
        int   off  = pos % slot;
        out_t r    = OFF;
        if (off >= gap) begin
            r.cat = ~s[d*7 +: 7];
            if (m[d]) r.sel = 4'b0001 << d;
            r.fd = (d == 3) && (off == slot - 1);
        end
        return r;
    endfunction

    task automatic push(int t0, int t1, logic [27:0] s, logic [3:0] m, int gap);
        for (int t = t0; t <= t1; t++) expq.push_back(expect_at(t, s, m, gap));
    endtask

    task automatic push_off(int n);
        for (int i = 0; i < n; i++) expq.push_back(OFF);
    endtask

    task automatic check(string name, out_t act, out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got cat=%h sel=%b fd=%b, want cat=%h sel=%b fd=%b",
                     name, act.cat, act.sel, act.fd, exp.cat, exp.sel, exp.fd);
        end
    endtask

    task automatic run(string name, int n, bit which);
        out_t e;
        out_t a;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            a = which ? {cat0, sel0, fd0} : {cat, sel, fd};
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: scoreboard empty, got cat=%h sel=%b", name, a.cat, a.sel);
            end else begin
                e = expq.pop_front();
                check(name, a, e);
            end
        end
    endtask

    initial begin
        int   selcnt;
        out_t a;

        vecs[0] = '{{7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'b1111, 16};
        vecs[1] = '{{7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'b1011, 12};
        vecs[2] = '{{7'h07, 7'h7D, 7'h6D, 7'h66}, 4'b0110, 8};
        vecs[3] = '{{7'h00, 7'h7F, 7'h01, 7'h40}, 4'b1001, 8};

        rst = 1'b1; en = 1'b0; en0 = 1'b0; seg = vecs[0].seg; mask = 4'hF;
`ifdef SEG_SCAN_PWM_EN
        enp = 1'b0; bri = 4'd0;
`endif
        #2;
        a = {cat, sel, fd};    check("reset", a, OFF);
        a = {cat0, sel0, fd0}; check("reset_gap0", a, OFF);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven full scans, two frames each.
        for (int v = 0; v < 4; v++) begin
            seg = vecs[v].seg; mask = vecs[v].mask; en = 1'b1;
            push(1, 40, vecs[v].seg, vecs[v].mask, 1);
            selcnt = 0;
            for (int i = 0; i < 40; i++) begin
                run("scan", 1, 1'b0);
                if (sel != 4'b0000) selcnt++;
            end
            checks++;
            if (selcnt != 2 * vecs[v].sel_cycles) begin
                errors++;
                $display("FAIL sel_duty vec%0d: got %0d want %0d", v, selcnt, 2 * vecs[v].sel_cycles);
            end
            en = 1'b0;
            push_off(1);
            run("disable_off", 1, 1'b0);
        end

        // Async reset mid-dwell, then restart.
        seg = vecs[0].seg; mask = 4'hF; en = 1'b1;
        push(1, 3, seg, mask, 1);
        run("pre_reset", 3, 1'b0);
        #2 rst = 1'b1;
        #1;
        a = {cat, sel, fd}; check("async_reset", a, OFF);
        @(negedge clk) rst = 1'b0;
        push(1, 5, seg, mask, 1);
        run("after_reset", 5, 1'b0);
        en = 1'b0;
        push_off(1);
        run("disable_off", 1, 1'b0);

        // Disable during digit 2: dark next edge, no frame_done, clean restart.
        en = 1'b1;
        push(1, 12, seg, mask, 1);
        run("to_digit2", 12, 1'b0);
        en = 1'b0;
        push_off(10);
        run("disabled", 10, 1'b0);
        en = 1'b1;
        push(1, 10, seg, mask, 1);
        run("reenable", 10, 1'b0);
        en = 1'b0;
        push_off(1);
        run("disable_off", 1, 1'b0);

        // Update seg_data mid-dwell of digit 0: takes effect at digit 1.
        seg = vecs[0].seg; en = 1'b1;
        push(1, 5, vecs[0].seg, 4'hF, 1);
        push(6, 20, vecs[2].seg, 4'hF, 1);
        run("tear_a", 3, 1'b0);
        seg = vecs[2].seg;
        run("tear_b", 17, 1'b0);
        en = 1'b0;
        push_off(1);
        run("disable_off", 1, 1'b0);

        // GAP=0: back-to-back digits, 16-cycle frame.
        seg = vecs[0].seg; mask = 4'hF; en0 = 1'b1;
        push(1, 32, seg, mask, 0);
        run("gap0", 32, 1'b1);
        en0 = 1'b0;
        push_off(1);
        run("gap0_off", 1, 1'b1);

`ifdef SEG_SCAN_PWM_EN
        begin
            int blev[3] = '{4, 15, 0};
            int bexp[3] = '{4, 16, 0};
            for (int k = 0; k < 3; k++) begin
                bri = blev[k][3:0]; enp = 1'b1;
                @(posedge clk); #1;
                selcnt = 0;
                for (int i = 0; i < 16; i++) begin
                    @(posedge clk); #1;
                    if (selp[0]) selcnt++;
                end
                checks++;
                if (selcnt != bexp[k]) begin
                    errors++;
                    $display("FAIL pwm bri=%0d: got %0d want %0d active cycles", blev[k], selcnt, bexp[k]);
                end
                enp = 1'b0;
                @(posedge clk); #1;
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
